// File: rtl/dmem_responder.sv
// Variable-latency data-memory responder: one load/store at a time over valid/ready,
// served from a byte-addressed RAM after LATENCY cycles, answered over a second valid/ready.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_addrmode,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    if (LATENCY < 1) begin : g_latency_check
        $error("dmem_responder: LATENCY must be at least 1");
    end

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    lat_write;
    logic                    lat_byte;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [7:0]              mem [0:(1<<ADDR_WIDTH)-1];
    logic                    accept;
    logic                    do_op;
    logic                    misaligned;
    logic [ADDR_WIDTH-1:0]   w0, w1, w2, w3;
    logic [DATA_WIDTH-1:0]   rdata_next;
    logic                    unused_addr;

    // Address bits above the RAM size alias onto the same storage.
    assign unused_addr = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    assign accept     = (state == IDLE) && req_valid && req_ready;
    assign do_op      = (state == WAIT) && (cnt == '0);
    assign misaligned = !lat_byte && (lat_addr[1:0] != 2'b00);

    // An aligned word never straddles the top of the RAM, so no wrap is needed here.
    assign w0 = {lat_addr[ADDR_WIDTH-1:2], 2'd0};
    assign w1 = {lat_addr[ADDR_WIDTH-1:2], 2'd1};
    assign w2 = {lat_addr[ADDR_WIDTH-1:2], 2'd2};
    assign w3 = {lat_addr[ADDR_WIDTH-1:2], 2'd3};

    always_comb begin
        rdata_next = '0;
        if (!lat_write && !misaligned) begin
            if (lat_byte) rdata_next = DATA_WIDTH'(mem[lat_addr]);
            else          rdata_next = DATA_WIDTH'({mem[w3], mem[w2], mem[w1], mem[w0]});
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_byte  <= req_addrmode;
            lat_addr  <= req_addr[ADDR_WIDTH-1:0];
            lat_wdata <= req_wdata;
        end
    end

    // RAM is deliberately outside the reset domain so its contents survive rst.
    always_ff @(posedge clk) begin
        if (do_op && lat_write && !misaligned) begin
            if (lat_byte) begin
                mem[lat_addr] <= lat_wdata[7:0];
            end else begin
                mem[w0] <= lat_wdata[7:0];
                mem[w1] <= lat_wdata[15:8];
                mem[w2] <= lat_wdata[23:16];
                mem[w3] <= lat_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        cnt       <= CNT_W'(LATENCY - 1);
                        state     <= WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_next;
                        rsp_err   <= misaligned;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance driven by directed and random traffic
// against a byte-array reference model, plus a LATENCY=1 instance for aliasing/timing.
module tb_dmem_responder;
    localparam int AW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_write, req_addrmode;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic        req_valid1, req_ready1, req_write1, req_addrmode1;
    logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
    logic        rsp_valid1, rsp_ready1, rsp_err1;

    int n_err = 0;
    int n_chk = 0;
    logic [7:0] refm [0:(1<<AW)-1];

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addrmode(req_addrmode), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write1), .req_addrmode(req_addrmode1), .req_addr(req_addr1),
        .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1));

    // Reference: RAM is a flat byte array indexed by address modulo its size.
    function automatic void model_access(input bit wr, input bit bm, input logic [31:0] addr,
                                         input logic [31:0] wd, output logic [31:0] rd,
                                         output logic er);
        int unsigned a = addr % (1 << AW);
        rd = 32'd0;
        er = !bm && (a % 4 != 0);
        if (er) return;
        if (wr) begin
            if (bm) refm[a] = wd[7:0];
            else for (int i = 0; i < 4; i++) refm[a + i] = wd[8*i +: 8];
        end else begin
            if (bm) rd = {24'd0, refm[a]};
            else for (int i = 0; i < 4; i++) rd[8*i +: 8] = refm[a + i];
        end
    endfunction

    task automatic send_req(input bit wr, input bit bm, input logic [31:0] addr, input logic [31:0] wd);
        int guard = 0;
        req_valid = 1'b1; req_write = wr; req_addrmode = bm; req_addr = addr; req_wdata = wd;
        while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        n_chk++;
        if (guard >= 20) begin
            n_err++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, guard);
        end
        @(negedge clk);
        req_valid = 1'b0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic xact(input bit wr, input bit bm, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output bit after);
        send_req(wr, bm, addr, wd);
        wait_rsp(lat);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        after = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (rsp_rdata === 32'd0) && (rsp_err === 1'b0);
    endtask

    typedef struct { bit wr; bit bm; logic [31:0] addr; logic [31:0] wd; } op_t;

    task automatic run_ops(input string tag, input op_t ops[$]);
        logic [31:0] rd, e_rd;
        logic er, e_er;
        int lat;
        bit after;
        foreach (ops[i]) begin
            model_access(ops[i].wr, ops[i].bm, ops[i].addr, ops[i].wd, e_rd, e_er);
            xact(ops[i].wr, ops[i].bm, ops[i].addr, ops[i].wd, rd, er, lat, after);
            n_chk += 4;
            if (rd !== e_rd) begin n_err++; $display("FAIL %s[%0d] rdata: got %h want %h", tag, i, rd, e_rd); end
            if (er !== e_er) begin n_err++; $display("FAIL %s[%0d] err: got %b want %b", tag, i, er, e_er); end
            if (lat != 2) begin n_err++; $display("FAIL %s[%0d] latency: got %0d want 2", tag, i, lat); end
            if (!after) begin n_err++; $display("FAIL %s[%0d] post_handshake: valid=%b ready=%b want 0/1", tag, i, rsp_valid, req_ready); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk += 4;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset req_ready: got %b want 0", req_ready); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'd0) begin n_err++; $display("FAIL reset rsp_rdata: got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset rsp_err: got %b want 0", rsp_err); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_release req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word_store_load();
        op_t ops[$];
        ops.push_back('{1'b1, 1'b0, 32'h100, 32'hDEADBEEF});
        ops.push_back('{1'b0, 1'b0, 32'h100, 32'h0});
        run_ops("word", ops);
    endtask

    task automatic test_byte_merge();
        op_t ops[$];
        ops.push_back('{1'b1, 1'b0, 32'h200, 32'h11223344});
        ops.push_back('{1'b1, 1'b1, 32'h202, 32'hFFFFFFAB});
        ops.push_back('{1'b0, 1'b0, 32'h200, 32'h0});
        ops.push_back('{1'b0, 1'b1, 32'h202, 32'h0});
        run_ops("merge", ops);
    endtask

    task automatic test_misaligned();
        op_t ops[$];
        ops.push_back('{1'b1, 1'b0, 32'h104, 32'h0BADF00D});
        ops.push_back('{1'b0, 1'b0, 32'h101, 32'h0});
        ops.push_back('{1'b1, 1'b0, 32'h105, 32'hFFFFFFFF});
        ops.push_back('{1'b0, 1'b0, 32'h104, 32'h0});
        run_ops("misalign", ops);
    endtask

    task automatic test_backpressure();
        logic [31:0] e_rd;
        logic e_er;
        int lat;
        model_access(1'b0, 1'b0, 32'h100, 32'h0, e_rd, e_er);
        rsp_ready = 1'b0;
        send_req(1'b0, 1'b0, 32'h100, 32'h0);
        wait_rsp(lat);
        n_chk++;
        if (lat != 2) begin n_err++; $display("FAIL bp latency: got %0d want 2", lat); end
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e_rd || req_ready !== 1'b0)
                begin n_err++; $display("FAIL bp hold[%0d]: valid=%b rdata=%h ready=%b want 1/%h/0", k, rsp_valid, rsp_rdata, req_ready, e_rd); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || req_ready !== 1'b1)
            begin n_err++; $display("FAIL bp release: valid=%b rdata=%h ready=%b want 0/0/1", rsp_valid, rsp_rdata, req_ready); end
    endtask

    task automatic test_reset_mid_op();
        op_t ops[$];
        logic [31:0] e_rd;
        logic e_er;
        int lat;
        ops.push_back('{1'b1, 1'b1, 32'h300, 32'h0});
        run_ops("rst_pre", ops);
        // Byte store of 0x55 is dropped by a reset while waiting.
        send_req(1'b1, 1'b1, 32'h300, 32'h55);
        rst = 1'b0;
        #1;
        n_chk++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
            begin n_err++; $display("FAIL rst_wait outputs: ready=%b valid=%b rdata=%h err=%b want 0/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err); end
        @(negedge clk);
        rst = 1'b1;
        ops.delete();
        ops.push_back('{1'b0, 1'b1, 32'h300, 32'h0});
        run_ops("rst_wait_load", ops);
        // A reset in RESP drops the response but the store is already in the RAM.
        model_access(1'b1, 1'b0, 32'h500, 32'hCAFEF00D, e_rd, e_er);
        rsp_ready = 1'b0;
        send_req(1'b1, 1'b0, 32'h500, 32'hCAFEF00D);
        wait_rsp(lat);
        rst = 1'b0;
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp rsp_valid: got %b want 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        ops.delete();
        ops.push_back('{1'b0, 1'b0, 32'h500, 32'h0});
        run_ops("rst_resp_load", ops);
    endtask

    task automatic test_random();
        op_t ops[$];
        for (int i = 0; i < 16; i++) ops.push_back('{1'b1, 1'b0, 32'h400 + 4 * i, $urandom});
        for (int i = 0; i < 40; i++) begin
            op_t o;
            o.wr = $urandom_range(0, 1);
            o.bm = $urandom_range(0, 1);
            o.addr = 32'h400 + $urandom_range(0, 63);
            if (!o.bm && $urandom_range(0, 3) != 0) o.addr[1:0] = 2'b00;
            o.addr = o.addr | (32'($urandom_range(0, 7)) << AW);
            o.wd = $urandom;
            ops.push_back(o);
        end
        run_ops("random", ops);
    endtask

    task automatic test_alias_latency1();
        logic [31:0] d = $urandom;
        logic [31:0] addrs [2];
        int lat, guard;
        addrs[0] = 32'h00020010;
        addrs[1] = 32'h00000010;
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            req_valid1 = 1'b1; req_write1 = (i == 0); req_addrmode1 = 1'b0;
            req_addr1 = addrs[i]; req_wdata1 = d;
            while (req_ready1 !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
            @(negedge clk);
            req_valid1 = 1'b0;
            lat = 0;
            while (rsp_valid1 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
            n_chk += 3;
            if (lat != 1) begin n_err++; $display("FAIL lat1[%0d] latency: got %0d want 1", i, lat); end
            if (rsp_err1 !== 1'b0) begin n_err++; $display("FAIL lat1[%0d] err: got %b want 0", i, rsp_err1); end
            if (rsp_rdata1 !== ((i == 0) ? 32'd0 : d))
                begin n_err++; $display("FAIL lat1[%0d] rdata: got %h want %h", i, rsp_rdata1, (i == 0) ? 32'd0 : d); end
            @(negedge clk);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addrmode = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addrmode1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
        rsp_ready1 = 1'b1;
        test_reset();
        test_word_store_load();
        test_byte_merge();
        test_misaligned();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_alias_latency1();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
